// File: rtl/sipo_pkg.sv
// rtl/sipo_pkg.sv - state encodings and parity helper for the SIPO receiver
//
// Purpose: shared definitions for sipo_rx and sipo_shift_reg.
// Ports: none (package).
// Configuration: ST_PARITY is only reachable when PARITY_EN is defined.

package sipo_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SHIFT  = 2'd1;
    localparam logic [1:0] ST_PARITY = 2'd2;

    typedef enum logic [1:0] {
        IDLE   = ST_IDLE,
        SHIFT  = ST_SHIFT,
        PARITY = ST_PARITY
    } state_t;

    // Bit that makes the total number of ones (data + this bit) even.
    function automatic logic even_parity(input logic [63:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/sipo_shift_reg.sv
// rtl/sipo_shift_reg.sv - n-bit MSB-first shift register with bit counter
//
// Purpose: accumulates serial bits; the first bit of a frame lands in bit 0
//          and migrates towards bit n-1 as later bits are shifted in.
// Ports:
//   clk        in  1      clock, posedge
//   clear      in  1      synchronous clear of word and count (highest priority)
//   load_first in  1      start a new frame with din as its first bit, count=1
//   shift      in  1      shift din into bit 0, count++
//   din        in  1      serial data bit
//   word       out n      accumulated bits
//   count      out CNT_W  number of bits collected in the current frame

module sipo_shift_reg
    import sipo_pkg::*;
#(
    parameter int n     = 8,
    parameter int CNT_W = $clog2(n + 1)
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             load_first,
    input  logic             shift,
    input  logic             din,
    output logic [n-1:0]     word,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk) begin
        if (clear) begin
            word  <= '0;
            count <= '0;
        end else if (load_first) begin
            word  <= {{(n-1){1'b0}}, din};
            count <= CNT_W'(1);
        end else if (shift) begin
            word  <= {word[n-2:0], din};
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/sipo_rx.sv
// rtl/sipo_rx.sv - serial-in parallel-out receiver with valid/ready output register
//
// Purpose: collects MSB-first frames into n-bit words, delivers them on a
//          valid/ready register, flags aborted frames and dropped words.
// Configuration: define PARITY_EN to append one even-parity bit per frame
//          (adds the PARITY state and drives par_err_o); otherwise par_err_o is 0.
// Ports:
//   clk_i      in  1  clock, posedge
//   rst_i      in  1  synchronous active-high reset
//   din_i      in  1  serial data bit
//   en_i       in  1  bit strobe for din_i
//   start_i    in  1  with en_i: din_i is the first bit of a new frame
//   dout_o     out n  received word
//   valid_o    out 1  dout_o holds an undelivered word
//   ready_i    in  1  consumer accepts dout_o
//   busy_o     out 1  frame in progress
//   abort_o    out 1  pulse: frame restarted before completion
//   overrun_o  out 1  pulse: completed word dropped, output occupied
//   par_err_o  out 1  parity error of the word on dout_o

module sipo_rx
    import sipo_pkg::*;
#(
    parameter int n = 8
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         din_i,
    input  logic         en_i,
    input  logic         start_i,
    output logic [n-1:0] dout_o,
    output logic         valid_o,
    input  logic         ready_i,
    output logic         busy_o,
    output logic         abort_o,
    output logic         overrun_o,
    output logic         par_err_o
);

    localparam int CNT_W = $clog2(n + 1);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(n - 1);

    state_t           state, state_nxt;
    logic [n-1:0]     word;
    logic [n-1:0]     deliver_word;
    logic [CNT_W-1:0] count;
    logic             sr_shift, sr_load;
    logic             deliver, abort_nxt;
`ifdef PARITY_EN
    logic             perr_nxt;
`endif

    sipo_shift_reg #(.n(n), .CNT_W(CNT_W)) u_shift (
        .clk        (clk_i),
        .clear      (rst_i),
        .load_first (sr_load),
        .shift      (sr_shift),
        .din        (din_i),
        .word       (word),
        .count      (count)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt    = state;
        sr_shift     = 1'b0;
        sr_load      = 1'b0;
        deliver      = 1'b0;
        abort_nxt    = 1'b0;
        // Without parity the word is delivered on the edge that samples its
        // last bit, so it must include din_i already.
        deliver_word = {word[n-2:0], din_i};
`ifdef PARITY_EN
        perr_nxt     = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (en_i && start_i) begin
                    sr_load   = 1'b1;
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (en_i && start_i) begin
                    abort_nxt = 1'b1;
                    sr_load   = 1'b1;
                end else if (en_i) begin
                    sr_shift = 1'b1;
                    if (count == LAST_IDX) begin
`ifdef PARITY_EN
                        state_nxt = PARITY;
`else
                        deliver   = 1'b1;
                        state_nxt = IDLE;
`endif
                    end
                end
            end
`ifdef PARITY_EN
            PARITY: begin
                if (en_i && start_i) begin
                    abort_nxt = 1'b1;
                    sr_load   = 1'b1;
                    state_nxt = SHIFT;
                end else if (en_i) begin
                    deliver      = 1'b1;
                    deliver_word = word;
                    perr_nxt     = even_parity(64'(word)) ^ din_i;
                    state_nxt    = IDLE;
                end
            end
`endif
            default: state_nxt = IDLE;
        endcase
    end

    // Output register: a delivery may replace a word being accepted on the
    // same edge, so valid_o stays high without a bubble.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            dout_o    <= '0;
            valid_o   <= 1'b0;
            abort_o   <= 1'b0;
            overrun_o <= 1'b0;
        end else begin
            abort_o   <= abort_nxt;
            overrun_o <= deliver && valid_o && !ready_i;
            if (deliver && (!valid_o || ready_i)) begin
                dout_o  <= deliver_word;
                valid_o <= 1'b1;
            end else if (valid_o && ready_i) begin
                valid_o <= 1'b0;
            end
        end
    end

`ifdef PARITY_EN
    always_ff @(posedge clk_i) begin
        if (rst_i)
            par_err_o <= 1'b0;
        else if (deliver && (!valid_o || ready_i))
            par_err_o <= perr_nxt;
    end
`else
    assign par_err_o = 1'b0;
`endif

    assign busy_o = (state != IDLE);

endmodule

// File: tb/tb_sipo_rx.sv
// tb/tb_sipo_rx.sv - self-checking bench for sipo_rx against a frame-level model

module tb_sipo_rx;

    localparam int N = 8;
`ifdef PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif

    logic         clk_i = 1'b0;
    logic         rst_i = 1'b1;
    logic         din_i = 1'b0;
    logic         en_i = 1'b0;
    logic         start_i = 1'b0;
    logic         ready_i = 1'b0;
    logic [N-1:0] dout_o;
    logic         valid_o, busy_o, abort_o, overrun_o, par_err_o;

    sipo_rx #(.n(N)) dut (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .din_i     (din_i),
        .en_i      (en_i),
        .start_i   (start_i),
        .dout_o    (dout_o),
        .valid_o   (valid_o),
        .ready_i   (ready_i),
        .busy_o    (busy_o),
        .abort_o   (abort_o),
        .overrun_o (overrun_o),
        .par_err_o (par_err_o)
    );

    always #5 clk_i = ~clk_i;

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: bits_seen = -1 means no frame in progress.
    int           bits_seen = -1;
    int           acc = 0;
    logic [N-1:0] m_dout = '0;
    bit           m_valid = 0, m_abort = 0, m_over = 0, m_perr = 0;
    int           abort_pulses = 0, over_pulses = 0;

    task automatic model_edge(input bit r, input bit e, input bit s, input bit d, input bit rdy);
        bit deliver = 0;
        int w = 0;
        bit pe = 0;
        if (r) begin
            bits_seen = -1; acc = 0; m_dout = '0;
            m_valid = 0; m_abort = 0; m_over = 0; m_perr = 0;
            return;
        end
        m_abort = 0;
        m_over  = 0;
        if (e) begin
            if (s) begin
                if (bits_seen >= 0) m_abort = 1;
                acc = int'(d);
                bits_seen = 1;
            end else if (bits_seen >= 0) begin
                if (bits_seen < N) begin
                    acc = (acc * 2 + int'(d)) % (1 << N);
                    bits_seen++;
                    if (bits_seen == N && !PAR) begin
                        deliver = 1; w = acc; bits_seen = -1;
                    end
                end else begin
                    deliver = 1; w = acc;
                    pe = bit'(($countones(acc) + int'(d)) % 2);
                    bits_seen = -1;
                end
            end
        end
        if (deliver) begin
            if (!m_valid || rdy) begin
                m_dout = N'(w); m_valid = 1; m_perr = pe;
            end else begin
                m_over = 1;
            end
        end else if (m_valid && rdy) begin
            m_valid = 0;
        end
    endtask

    task automatic compare_all();
        check("dout",    32'(dout_o),    32'(m_dout));
        check("valid",   32'(valid_o),   32'(m_valid));
        check("busy",    32'(busy_o),    32'(bits_seen >= 0));
        check("abort",   32'(abort_o),   32'(m_abort));
        check("overrun", 32'(overrun_o), 32'(m_over));
        check("par_err", 32'(par_err_o), 32'(m_perr));
        if (abort_o)   abort_pulses++;
        if (overrun_o) over_pulses++;
    endtask

    task automatic cyc(input bit r, input bit e, input bit s, input bit d, input bit rdy);
        rst_i = r; en_i = e; start_i = s; din_i = d; ready_i = rdy;
        @(posedge clk_i);
        model_edge(r, e, s, d, rdy);
        @(negedge clk_i);
        compare_all();
    endtask

    // Sends a frame of nb bits (MSB first), optional parity bit, with gaps.
    task automatic send(input logic [N-1:0] w, input int nb, input bit with_par,
                        input bit par_bit, input bit rdy, input int gap);
        for (int i = 0; i < nb; i++) begin
            cyc(0, 1, i == 0, w[N-1-i], rdy);
            if (!(i == nb - 1 && !with_par))
                for (int g = 0; g < gap; g++) cyc(0, 0, 0, 0, rdy);
        end
        if (with_par) cyc(0, 1, 0, par_bit, rdy);
    endtask

    initial begin
        @(negedge clk_i);
        cyc(1, 0, 0, 0, 0);
        cyc(1, 1, 1, 1, 1);
        check("reset_dout", 32'(dout_o), 32'h0);
        check("reset_valid", 32'(valid_o), 32'h0);
        check("reset_busy", 32'(busy_o), 32'h0);

        // 1: single frame, ready high
        send(8'hA5, N, PAR, 1'b0, 1, 0);
        check("t1_dout", 32'(dout_o), 32'hA5);
        check("t1_valid", 32'(valid_o), 32'h1);
        cyc(0, 0, 0, 0, 1);
        check("t1_valid_clr", 32'(valid_o), 32'h0);

        // 2: gapped frame, busy stays high throughout
        cyc(0, 1, 1, 1, 1);
        for (int i = 1; i < N + int'(PAR); i++) begin
            for (int g = 0; g < 3; g++) begin
                cyc(0, 0, 0, 0, 1);
                check("t2_busy", 32'(busy_o), 32'h1);
            end
            cyc(0, 1, 0, (i < N) ? 1'(8'hA5 >> (N - 1 - i)) : 1'b0, 1);
        end
        check("t2_dout", 32'(dout_o), 32'hA5);
        check("t2_valid", 32'(valid_o), 32'h1);
        cyc(0, 0, 0, 0, 1);

        // 3: two frames while consumer stalls
        over_pulses = 0;
        send(8'h3C, N, PAR, 1'b0, 0, 0);
        send(8'hC3, N, PAR, 1'b0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        check("t3_dout", 32'(dout_o), 32'h3C);
        check("t3_overrun_pulses", 32'(over_pulses), 32'd1);
        cyc(0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 1);
        check("t3_drained", 32'(valid_o), 32'h0);

        // 4: abort after 4 bits, new frame 0x81
        abort_pulses = 0;
        send(8'hF0, 4, 0, 1'b0, 1, 0);
        send(8'h81, N, PAR, 1'b0, 1, 0);
        cyc(0, 0, 0, 0, 0);
        check("t4_abort_pulses", 32'(abort_pulses), 32'd1);
        check("t4_dout", 32'(dout_o), 32'h81);
        cyc(0, 0, 0, 0, 1);

        // 5: reset mid-frame, then strobes without start are ignored
        send(8'hFF, 5, 0, 1'b0, 1, 0);
        cyc(1, 0, 0, 0, 1);
        for (int i = 0; i < 12; i++) cyc(0, 1, 0, 1, 1);
        check("t5_busy", 32'(busy_o), 32'h0);
        check("t5_valid", 32'(valid_o), 32'h0);
        check("t5_dout", 32'(dout_o), 32'h0);

`ifdef PARITY_EN
        // 6: parity good then bad
        send(8'hA5, N, 1, 1'b0, 1, 0);
        check("t6_perr_ok", 32'(par_err_o), 32'h0);
        cyc(0, 0, 0, 0, 1);
        send(8'hA5, N, 1, 1'b1, 1, 0);
        check("t6_perr_bad", 32'(par_err_o), 32'h1);
        check("t6_dout", 32'(dout_o), 32'hA5);
        cyc(0, 0, 0, 0, 1);
`endif

        // Random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            bit e, s, d, rdy, r;
            r   = ($urandom_range(0, 299) == 0);
            e   = ($urandom_range(0, 1) == 1);
            s   = e && ($urandom_range(0, 13) == 0);
            d   = 1'($urandom);
            rdy = ($urandom_range(0, 9) < 7);
            cyc(r, e, s, d, rdy);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1);
    end

endmodule
